// File: rtl/icache_pkg.sv
// Shared definitions for the I-cache controller: bus encodings, derived
// widths, the MSHR entry record and line-address split helpers.
package icache_pkg;

  localparam int unsigned ADDR_W    = 64;
  localparam int unsigned IDX_W     = 5;
  localparam int unsigned TAG_W     = 56;
  localparam int unsigned MEM_TAG_W = 4;
  localparam int unsigned N_MSHR    = 4;
  localparam int unsigned PF_DIST   = 2;

  localparam int unsigned LA_W  = ADDR_W - 3;
  localparam int unsigned SEL_W = (N_MSHR > 1) ? $clog2(N_MSHR) : 1;
  localparam int unsigned CNT_W = $clog2(PF_DIST + 1);

  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;

  typedef logic [LA_W-1:0] la_t;

  typedef struct packed {
    logic                 valid;
    logic [MEM_TAG_W-1:0] mem_tag;
    la_t                  la;
  } mshr_entry_t;

  typedef enum logic {PF_IDLE = 1'b0, PF_RUN = 1'b1} pf_state_t;

  // Line address of a byte address (drops the 3 offset bits).
  function automatic la_t la_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:3];
  endfunction

  function automatic logic [IDX_W-1:0] idx_of(input la_t la);
    return la[IDX_W-1:0];
  endfunction

  function automatic logic [TAG_W-1:0] tag_of(input la_t la);
    return la[LA_W-1:IDX_W];
  endfunction

endpackage

// File: rtl/icache_mshr.sv
// Outstanding line-load table.
// Ports: clk/rst; dem_la/pf_la -> dem_busy/pf_busy in-flight lookups;
// fill_tag -> fill_hit/fill_la tag match (entry cleared at the edge);
// full flag; alloc_en/alloc_tag/alloc_la write the lowest free entry.
module icache_mshr
  import icache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  la_t                  dem_la,
  input  la_t                  pf_la,
  output logic                 dem_busy,
  output logic                 pf_busy,
  input  logic [MEM_TAG_W-1:0] fill_tag,
  output logic                 fill_hit,
  output la_t                  fill_la,
  output logic                 full,
  input  logic                 alloc_en,
  input  logic [MEM_TAG_W-1:0] alloc_tag,
  input  la_t                  alloc_la
);

  mshr_entry_t            ent [N_MSHR];
  logic [SEL_W-1:0]       fill_sel;
  logic [SEL_W-1:0]       free_sel;
  logic                   free_found;

  // Lookups; descending scan so the lowest matching / free index wins.
  always_comb begin
    dem_busy   = 1'b0;
    pf_busy    = 1'b0;
    fill_hit   = 1'b0;
    fill_sel   = '0;
    fill_la    = '0;
    full       = 1'b1;
    free_sel   = '0;
    free_found = 1'b0;
    for (int i = int'(N_MSHR) - 1; i >= 0; i--) begin
      if (ent[i].valid) begin
        if (ent[i].la == dem_la) dem_busy = 1'b1;
        if (ent[i].la == pf_la)  pf_busy  = 1'b1;
        if (fill_tag != '0 && ent[i].mem_tag == fill_tag) begin
          fill_hit = 1'b1;
          fill_sel = SEL_W'(i);
          fill_la  = ent[i].la;
        end
      end else begin
        full       = 1'b0;
        free_found = 1'b1;
        free_sel   = SEL_W'(i);
      end
    end
  end

  // A filling entry is still valid, so it is never the allocation target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(N_MSHR); i++) ent[i] <= '0;
    end else begin
      if (fill_hit) ent[fill_sel].valid <= 1'b0;
      if (alloc_en && free_found)
        ent[free_sel] <= '{valid: 1'b1, mem_tag: alloc_tag, la: alloc_la};
    end
  end

endmodule

// File: rtl/icache_ctrl.sv
// I-cache controller: demand lookup, miss/prefetch arbitration onto the
// tagged memory bus, fill writes into cachemem and fill forwarding to fetch.
// Ports: proc_* fetch side; rd_* demand lookup; pf_* prefetch probe;
// wr_* fill write; mem_* tagged non-blocking memory bus.
module icache_ctrl
  import icache_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 proc_rd_en_i,
  input  logic [ADDR_W-1:0]    proc_addr_i,
  output logic [63:0]          proc_data_o,
  output logic                 proc_valid_o,
  output logic [IDX_W-1:0]     rd_idx_o,
  output logic [TAG_W-1:0]     rd_tag_o,
  input  logic [63:0]          rd_data_i,
  input  logic                 rd_hit_i,
  output logic [IDX_W-1:0]     pf_idx_o,
  output logic [TAG_W-1:0]     pf_tag_o,
  input  logic                 pf_hit_i,
  output logic                 wr_en_o,
  output logic [IDX_W-1:0]     wr_idx_o,
  output logic [TAG_W-1:0]     wr_tag_o,
  output logic [63:0]          wr_data_o,
  output logic [1:0]           mem_cmd_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  input  logic [MEM_TAG_W-1:0] mem_resp_i,
  input  logic [MEM_TAG_W-1:0] mem_tag_i,
  input  logic [63:0]          mem_data_i
);

  pf_state_t        pf_state;
  la_t              pf_ptr;
  la_t              last_la;
  logic [CNT_W-1:0] pf_cnt;
  logic [CNT_W-1:0] pf_cnt_nxt;

  la_t  dem_la;
  la_t  fill_la;
  la_t  req_la;
  logic dem_busy, pf_busy, fill_hit, full;
  logic fwd, dem_req, pf_req, load, alloc_en, pf_accept;

  assign dem_la = la_of(proc_addr_i);

  icache_mshr u_mshr (
    .clk       (clk),
    .rst       (rst),
    .dem_la    (dem_la),
    .pf_la     (pf_ptr),
    .dem_busy  (dem_busy),
    .pf_busy   (pf_busy),
    .fill_tag  (mem_tag_i),
    .fill_hit  (fill_hit),
    .fill_la   (fill_la),
    .full      (full),
    .alloc_en  (alloc_en),
    .alloc_tag (mem_resp_i),
    .alloc_la  (req_la)
  );

  // Arbitration: demand over prefetch, nothing when the table is full.
  always_comb begin
    fwd       = fill_hit && (fill_la == dem_la);
    dem_req   = proc_rd_en_i && !rd_hit_i && !dem_busy && !fwd;
    pf_req    = (pf_state == PF_RUN) && !pf_hit_i && !pf_busy && (pf_ptr != dem_la);
    load      = !rst && !full && (dem_req || pf_req);
    req_la    = dem_req ? dem_la : pf_ptr;
    alloc_en  = load && (mem_resp_i != '0);
    pf_accept = alloc_en && !dem_req;
  end

  assign mem_cmd_o  = load ? BUS_LOAD : BUS_NONE;
  assign mem_addr_o = load ? {req_la, 3'b000} : '0;

  assign rd_idx_o = idx_of(dem_la);
  assign rd_tag_o = tag_of(dem_la);
  assign pf_idx_o = idx_of(pf_ptr);
  assign pf_tag_o = tag_of(pf_ptr);

  assign wr_en_o   = !rst && fill_hit;
  assign wr_idx_o  = idx_of(fill_la);
  assign wr_tag_o  = tag_of(fill_la);
  assign wr_data_o = mem_data_i;

  // Forwarding: a fill for the demand line satisfies fetch in the same cycle.
  assign proc_valid_o = !rst && proc_rd_en_i && (rd_hit_i || fwd);
  assign proc_data_o  = rd_hit_i ? rd_data_i : mem_data_i;

  assign pf_cnt_nxt = pf_cnt + CNT_W'(1);

  // Prefetch pointer: restart on a new fetch line, else walk ahead PF_DIST lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pf_state <= PF_IDLE;
      pf_ptr   <= '0;
      pf_cnt   <= '0;
      last_la  <= '1;
    end else if (proc_rd_en_i && (dem_la != last_la)) begin
      last_la  <= dem_la;
      pf_ptr   <= dem_la + LA_W'(1);
      pf_cnt   <= '0;
      pf_state <= PF_RUN;
    end else if (pf_state == PF_RUN && (pf_hit_i || pf_busy || pf_accept)) begin
      pf_ptr <= pf_ptr + LA_W'(1);
      pf_cnt <= pf_cnt_nxt;
      if (pf_cnt_nxt == CNT_W'(PF_DIST)) pf_state <= PF_IDLE;
    end
  end

endmodule
